// File: rtl/ram_bank_xbar.sv
// N-engine x M-bank crossbar with per-bank round-robin arbitration and a fixed 3-cycle read return.
// Optional conflict statistics counter is built when XBAR_STATS_EN is defined.
module ram_bank_xbar #(
   parameter int N_ENG  = 4,
   parameter int N_BANK = 4,
   parameter int SEL_W  = 3,
   parameter int AW     = 14,
   parameter int DW     = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_ENG-1:0]        eng_req,
   input  logic [N_ENG-1:0]        eng_wr,
   input  logic [N_ENG*SEL_W-1:0]  eng_sel,
   input  logic [N_ENG*AW-1:0]     eng_addr,
   input  logic [N_ENG*DW-1:0]     eng_wdata,
   output logic [N_ENG-1:0]        eng_gnt,
   output logic [N_ENG-1:0]        eng_rvalid,
   output logic [N_ENG*DW-1:0]     eng_rdata,
   output logic [N_BANK-1:0]       bank_rd,
   output logic [N_BANK-1:0]       bank_wr,
   output logic [N_BANK*AW-1:0]    bank_addr,
   output logic [N_BANK*DW-1:0]    bank_wdata,
   input  logic [N_BANK*DW-1:0]    bank_rdata,
   output logic                    sel_err,
   output logic [15:0]             stat_conf
);

   localparam int          EW = (N_ENG > 1) ? $clog2(N_ENG) : 1;
   localparam int unsigned NE = N_ENG;
   localparam int unsigned NB = N_BANK;

   logic [SEL_W-1:0] sel       [N_ENG];
   logic [N_ENG-1:0] bad;
   logic [N_BANK-1:0] win_vld;
   logic [N_BANK-1:0] win_wr;
   logic [EW-1:0]    win_idx   [N_BANK];
   logic [AW-1:0]    win_addr  [N_BANK];
   logic [DW-1:0]    win_wdata [N_BANK];
   logic [EW-1:0]    ptr       [N_BANK];
   logic [N_BANK-1:0] tag1_vld;
   logic [N_BANK-1:0] tag2_vld;
   logic [EW-1:0]    tag1_idx  [N_BANK];
   logic [EW-1:0]    tag2_idx  [N_BANK];
   logic             denied;

   // Pass 0 scans engines at or above ptr, pass 1 wraps to the ones below it.
   always_comb begin
      bad     = '0;
      eng_gnt = '0;
      win_vld = '0;
      win_wr  = '0;
      for (int unsigned e = 0; e < NE; e++) begin
         sel[e] = eng_sel[e*SEL_W +: SEL_W];
         if (eng_req[e] && 32'(sel[e]) >= NB) begin
            bad[e]     = 1'b1;
            eng_gnt[e] = 1'b1;
         end
      end
      for (int unsigned b = 0; b < NB; b++) begin
         win_idx[b]   = '0;
         win_addr[b]  = '0;
         win_wdata[b] = '0;
         for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned e = 0; e < NE; e++) begin
               if (!win_vld[b] && eng_req[e] && !bad[e] && 32'(sel[e]) == b &&
                   (p == 1 || e >= 32'(ptr[b]))) begin
                  win_vld[b]   = 1'b1;
                  win_wr[b]    = eng_wr[e];
                  win_idx[b]   = EW'(e);
                  win_addr[b]  = eng_addr[e*AW +: AW];
                  win_wdata[b] = eng_wdata[e*DW +: DW];
                  eng_gnt[e]   = 1'b1;
               end
            end
         end
      end
   end

   assign denied = |(eng_req & ~bad & ~eng_gnt);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bank_rd    <= '0;
         bank_wr    <= '0;
         bank_addr  <= '0;
         bank_wdata <= '0;
         tag1_vld   <= '0;
         tag2_vld   <= '0;
         for (int unsigned b = 0; b < NB; b++) begin
            ptr[b]      <= '0;
            tag1_idx[b] <= '0;
            tag2_idx[b] <= '0;
         end
      end else begin
         for (int unsigned b = 0; b < NB; b++) begin
            bank_rd[b]  <= win_vld[b] & ~win_wr[b];
            bank_wr[b]  <= win_vld[b] & win_wr[b];
            tag1_vld[b] <= win_vld[b] & ~win_wr[b];
            tag1_idx[b] <= win_idx[b];
            tag2_vld[b] <= tag1_vld[b];
            tag2_idx[b] <= tag1_idx[b];
            if (win_vld[b]) begin
               bank_addr[b*AW +: AW]  <= win_addr[b];
               bank_wdata[b*DW +: DW] <= win_wdata[b];
               ptr[b] <= (32'(win_idx[b]) == NE - 1) ? '0 : win_idx[b] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         eng_rvalid <= '0;
         eng_rdata  <= '0;
      end else begin
         eng_rvalid <= '0;
         for (int unsigned b = 0; b < NB; b++) begin
            for (int unsigned e = 0; e < NE; e++) begin
               if (tag2_vld[b] && 32'(tag2_idx[b]) == e) begin
                  eng_rvalid[e]          <= 1'b1;
                  eng_rdata[e*DW +: DW]  <= bank_rdata[b*DW +: DW];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sel_err <= 1'b0;
      end else if (|bad) begin
         sel_err <= 1'b1;
      end
   end

`ifdef XBAR_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_conf <= '0;
      end else if (denied && stat_conf != 16'hFFFF) begin
         stat_conf <= stat_conf + 16'd1;
      end
   end
`else
   assign stat_conf = '0;
`endif

endmodule

// File: tb/tb_ram_bank_xbar.sv
// Scoreboard bench for ram_bank_xbar: round-robin reference model, behavioural sync RAM banks,
// directed scenarios followed by randomized traffic.
module tb_ram_bank_xbar;

   localparam int NE = 4;
   localparam int NB = 4;
   localparam int SW = 3;
   localparam int AW = 14;
   localparam int DW = 8;
   localparam int DEPTH = 16384;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [NE-1:0]    req = '0, wr = '0;
   logic [NE*SW-1:0] sel = '0;
   logic [NE*AW-1:0] addr = '0;
   logic [NE*DW-1:0] wdata = '0;
   logic [NE-1:0]    gnt, rvalid;
   logic [NE*DW-1:0] rdata;
   logic [NB-1:0]    bank_rd, bank_wr;
   logic [NB*AW-1:0] bank_addr;
   logic [NB*DW-1:0] bank_wdata, bank_rdata;
   logic             sel_err;
   logic [15:0]      stat_conf;

   ram_bank_xbar #(.N_ENG(NE), .N_BANK(NB), .SEL_W(SW), .AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset),
      .eng_req(req), .eng_wr(wr), .eng_sel(sel), .eng_addr(addr), .eng_wdata(wdata),
      .eng_gnt(gnt), .eng_rvalid(rvalid), .eng_rdata(rdata),
      .bank_rd(bank_rd), .bank_wr(bank_wr), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
      .bank_rdata(bank_rdata), .sel_err(sel_err), .stat_conf(stat_conf)
   );

   typedef struct {
      int          eng;
      int          due;
      logic [7:0]  data;
   } exp_t;

   exp_t       exq[$];
   int         tests = 0, fails = 0;
   int         cyc = 0;
   bit         in_rst = 1'b1;
   int         m_ptr [NB];
   bit         m_err = 1'b0;
   int         m_stat = 0;
   logic [7:0] ref_mem [NB*DEPTH];
   bit         ref_wr  [NB*DEPTH];
   logic [7:0] env_mem [NB*DEPTH];
   bit         env_wr  [NB*DEPTH];

   function automatic logic [7:0] init_val(input int k);
      if (k == 1*DEPTH + 5) return 8'hA5;
      return 8'(k * 7 + (k >> 5) + 8'h3C);
   endfunction

   always @(posedge clk) cyc++;

   // Behavioural synchronous RAM banks
   always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         int k;
         k = b*DEPTH + int'(bank_addr[b*AW +: AW]);
         if (bank_wr[b]) begin
            env_mem[k] = bank_wdata[b*DW +: DW];
            env_wr[k]  = 1'b1;
         end
         if (bank_rd[b]) bank_rdata[b*DW +: DW] <= env_wr[k] ? env_mem[k] : init_val(k);
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic set_req(input int e, input bit w, input int s, input int a, input int d);
      req[e] = 1'b1;
      wr[e]  = w;
      sel[e*SW +: SW]   = SW'(s);
      addr[e*AW +: AW]  = AW'(a);
      wdata[e*DW +: DW] = DW'(d);
   endtask

   // One clock of the reference model: arbitration, memory shadow, expected returns.
   task automatic step();
      logic [NE-1:0] eg, acc;
      bit den;
      exp_t x;
      @(negedge clk);
      chk("sel_err", 64'(sel_err), 64'(m_err));
      chk("stat_conf", 64'(stat_conf), 64'(m_stat));
      eg  = '0;
      den = 1'b0;
      for (int e = 0; e < NE; e++)
         if (req[e] && int'(sel[e*SW +: SW]) >= NB) begin
            eg[e] = 1'b1;
            m_err = 1'b1;
         end
      for (int b = 0; b < NB; b++) begin
         bit found = 1'b0;
         for (int k = 0; k < NE; k++) begin
            int e, key;
            e = (m_ptr[b] + k) % NE;
            if (!found && req[e] && int'(sel[e*SW +: SW]) == b) begin
               found    = 1'b1;
               eg[e]    = 1'b1;
               m_ptr[b] = (e + 1) % NE;
               key = b*DEPTH + int'(addr[e*AW +: AW]);
               if (wr[e]) begin
                  ref_mem[key] = wdata[e*DW +: DW];
                  ref_wr[key]  = 1'b1;
               end else begin
                  x.eng  = e;
                  x.due  = cyc + 3;
                  x.data = ref_wr[key] ? ref_mem[key] : init_val(key);
                  exq.push_back(x);
               end
            end
         end
      end
      for (int e = 0; e < NE; e++)
         if (req[e] && int'(sel[e*SW +: SW]) < NB && !eg[e]) den = 1'b1;
      chk("gnt", 64'(gnt), 64'(eg));
`ifdef XBAR_STATS_EN
      if (den && m_stat < 65535) m_stat++;
`endif
      acc = req & eg;
      @(posedge clk);
      #1;
      req = req & ~acc;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic run_until_idle(input string nm);
      for (int i = 0; i < 10 && req != '0; i++) step();
      chk(nm, 64'(req), 64'(0));
   endtask

   task automatic chk_zero_outputs(input string nm);
      chk({nm, "_strobes"}, 64'({bank_rd, bank_wr}), 64'(0));
      chk({nm, "_baddr"}, 64'(bank_addr), 64'(0));
      chk({nm, "_bwdata"}, 64'(bank_wdata), 64'(0));
      chk({nm, "_rvalid"}, 64'(rvalid), 64'(0));
      chk({nm, "_rdata"}, 64'(rdata), 64'(0));
      chk({nm, "_sel_err"}, 64'(sel_err), 64'(0));
      chk({nm, "_stat"}, 64'(stat_conf), 64'(0));
   endtask

   // Monitor: pops every expectation due this cycle and compares the return bus.
   always @(negedge clk) begin
      logic [NE-1:0]    erv;
      logic [NE*DW-1:0] erd;
      exp_t x;
      if (!in_rst) begin
         erv = '0;
         erd = '0;
         while (exq.size() > 0 && exq[0].due <= cyc) begin
            x = exq.pop_front();
            if (x.due < cyc) begin
               tests++;
               fails++;
               $display("FAIL stale_return @cyc %0d: eng %0d due %0d", cyc, x.eng, x.due);
            end else begin
               erv[x.eng] = 1'b1;
               erd[x.eng*DW +: DW] = x.data;
            end
         end
         chk("rvalid", 64'(rvalid), 64'(erv));
         for (int e = 0; e < NE; e++)
            if (erv[e] && rvalid[e]) chk("rdata", 64'(rdata[e*DW +: DW]), 64'(erd[e*DW +: DW]));
      end
   end

   initial begin
      for (int b = 0; b < NB; b++) m_ptr[b] = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero_outputs("reset");
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      in_rst = 1'b0;

      // single read
      set_req(0, 1'b0, 1, 5, 0);
      step();
      chk("t1_bank_rd", 64'(bank_rd), 64'(4'b0010));
      chk("t1_bank_addr", 64'(bank_addr[1*AW +: AW]), 64'(5));
      idle(4);

      // four-way conflict on bank 2
      for (int e = 0; e < NE; e++) set_req(e, 1'b0, 2, 10 + e, 0);
      run_until_idle("t2_conflict_done");
      idle(5);

      // parallel, one engine per bank
      for (int e = 0; e < NE; e++) set_req(e, 1'b0, e, 20 + e, 0);
      step();
      chk("t3_all_granted", 64'(req), 64'(0));
      idle(5);

      // write then read at top address
      set_req(2, 1'b1, 3, 14'h3FFF, 8'h7E);
      step();
      set_req(2, 1'b0, 3, 14'h3FFF, 0);
      step();
      idle(5);

      // bad select
      set_req(1, 1'b0, 5, 3, 0);
      step();
      chk("t5_no_strobe", 64'({bank_rd, bank_wr}), 64'(0));
      idle(3);

      // reset during an in-flight read
      set_req(2, 1'b0, 2, 7, 0);
      step();
      step();
      in_rst = 1'b1;
      reset  = 1'b0;
      #2;
      chk_zero_outputs("t6_reset");
      exq.delete();
      for (int b = 0; b < NB; b++) m_ptr[b] = 0;
      m_err  = 1'b0;
      m_stat = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      in_rst = 1'b0;
      set_req(0, 1'b0, 2, 1, 0);
      set_req(3, 1'b0, 2, 2, 0);
      run_until_idle("t6_post_reset_done");
      idle(5);

      // randomized traffic
      for (int i = 0; i < 2500; i++) begin
         for (int e = 0; e < NE; e++) begin
            if (!req[e] && $urandom_range(0, 9) < 6) begin
               int s, a;
               s = ($urandom_range(0, 19) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
               a = int'($urandom_range(0, 8));
               if (a == 8) a = 14'h3FFF;
               set_req(e, ($urandom_range(0, 9) < 3), s, a, int'($urandom_range(0, 255)));
            end
         end
         step();
      end
      req = '0;
      idle(6);
      chk("drain_empty", 64'(exq.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
